// File: rtl/ma_packetizer.sv
// ma_packetizer: splits a boot stream into NoC task-image packets and one MA-descriptor packet
module ma_packetizer #(
  parameter int FLIT_SIZE = 32,
  parameter int MAX_TASKS = 8,
  parameter logic [31:0] SVC_TASK_ALLOC = 32'h40,
  parameter logic [31:0] SVC_MA_DESCR = 32'h41
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [15:0]          mapper_address_i,
  input  logic                 tx_i,
  output logic                 credit_o,
  input  logic [FLIT_SIZE-1:0] data_i,
  output logic                 tx_o,
  input  logic                 credit_i,
  output logic [FLIT_SIZE-1:0] data_o,
  output logic                 done_o,
  output logic                 error_o
);
  localparam int IW = MAX_TASKS > 1 ? $clog2(MAX_TASKS) : 1;
  typedef enum logic [3:0] {IDLE, T_PRE, T_HDR, T_PREOUT, T_BODY, D_CNT, D_HDR, D_BODY, DONE, ERR} state_t;
  state_t state, state_d;
  logic [FLIT_SIZE-1:0] pre [4];
  logic [15:0] tbl [MAX_TASKS];
  logic [31:0] cnt, task_q, n_q, bsz, tix, n_in;
  logic can_load, in_fire, ld, seg_end;
  logic [FLIT_SIZE-1:0] ld_data;
  assign n_in = 32'(data_i);
  assign bsz = (32'(pre[0]) + 32'(pre[1])) >> 2;
  assign tix = (cnt - 32'd1) >> 1;
  always_comb begin
    can_load = !tx_o || credit_i;
    credit_o = state == T_PRE || state == D_CNT || ((state == T_BODY || state == D_BODY) && can_load);
    in_fire = tx_i && credit_o;
    state_d = state;
    ld = 1'b0;
    ld_data = data_i;
    seg_end = 1'b0;
    case (state)
      IDLE: state_d = tx_i ? T_PRE : IDLE;
      T_PRE: state_d = in_fire && cnt == 32'd3 ? T_HDR : T_PRE;
      T_HDR: begin
        ld = can_load;
        ld_data = cnt == 32'd0 ? FLIT_SIZE'({16'b0, task_q == 32'd0 ? mapper_address_i : tbl[task_q[IW-1:0]]})
                : cnt == 32'd1 ? FLIT_SIZE'(32'd4 + bsz) : FLIT_SIZE'(SVC_TASK_ALLOC);
        state_d = ld && cnt == 32'd2 ? T_PREOUT : T_HDR;
      end
      T_PREOUT: begin
        ld = can_load;
        ld_data = pre[cnt[1:0]];
        state_d = ld && cnt == 32'd3 ? T_BODY : T_PREOUT;
        seg_end = ld && cnt == 32'd3 && bsz == 32'd0;
      end
      T_BODY: begin
        ld = in_fire;
        seg_end = in_fire && cnt == bsz - 32'd1;
      end
      D_CNT: state_d = !in_fire ? D_CNT : (n_in == 32'd0 || n_in > 32'(MAX_TASKS)) ? ERR : D_HDR;
      D_HDR: begin
        ld = can_load;
        ld_data = cnt == 32'd0 ? FLIT_SIZE'({16'b0, mapper_address_i})
                : cnt == 32'd1 ? FLIT_SIZE'(32'd2 + 32'd3 * n_q)
                : cnt == 32'd2 ? FLIT_SIZE'(SVC_MA_DESCR) : FLIT_SIZE'(n_q);
        state_d = ld && cnt == 32'd3 ? D_BODY : D_HDR;
      end
      D_BODY: begin
        ld = in_fire;
        if (in_fire && cnt == 32'd3 * n_q) state_d = n_q > 32'd1 ? T_PRE : DONE;
      end
      default: ;
    endcase
    // task 0 is the mapper image, which is always followed by the descriptor
    if (seg_end) state_d = task_q == 32'd0 ? D_CNT : task_q + 32'd1 < n_q ? T_PRE : DONE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      task_q <= '0;
      n_q <= '0;
      tx_o <= 1'b0;
      data_o <= '0;
      done_o <= 1'b0;
      error_o <= 1'b0;
      for (int i = 0; i < 4; i++) pre[i] <= '0;
      for (int i = 0; i < MAX_TASKS; i++) tbl[i] <= '0;
    end else begin
      state <= state_d;
      cnt <= state_d != state ? '0 : cnt + 32'(ld || in_fire);
      if (seg_end) task_q <= task_q + 32'd1;
      if (state == T_PRE && in_fire) pre[cnt[1:0]] <= data_i;
      if (state == D_CNT && in_fire) n_q <= n_in;
      // descriptor word k = cnt+1; even k >= 4 carries the PE address of task (k-2)/2
      if (state == D_BODY && in_fire && cnt[0] && cnt >= 32'd3 && tix < n_q) tbl[tix[IW-1:0]] <= data_i[15:0];
      tx_o <= ld || (tx_o && !credit_i);
      if (ld) data_o <= ld_data;
      done_o <= done_o || (state == DONE && !tx_o);
      error_o <= error_o || state == ERR;
    end
  end
endmodule
